// File: rtl/wisc_pkg.sv
// Shared WISC-F18 pipeline constants: opcodes, branch condition codes and flag layout.
package wisc_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned COND_W = 3;
    localparam int unsigned FLAG_W = 3;

    localparam logic [OP_W-1:0] OP_ADD    = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB    = 4'b0001;
    localparam logic [OP_W-1:0] OP_XOR    = 4'b0010;
    localparam logic [OP_W-1:0] OP_RED    = 4'b0011;
    localparam logic [OP_W-1:0] OP_SLL    = 4'b0100;
    localparam logic [OP_W-1:0] OP_SRA    = 4'b0101;
    localparam logic [OP_W-1:0] OP_ROR    = 4'b0110;
    localparam logic [OP_W-1:0] OP_PADDSB = 4'b0111;
    localparam logic [OP_W-1:0] OP_LW     = 4'b1000;
    localparam logic [OP_W-1:0] OP_SW     = 4'b1001;
    localparam logic [OP_W-1:0] OP_LLB    = 4'b1010;
    localparam logic [OP_W-1:0] OP_LHB    = 4'b1011;
    localparam logic [OP_W-1:0] OP_B      = 4'b1100;
    localparam logic [OP_W-1:0] OP_BR     = 4'b1101;
    localparam logic [OP_W-1:0] OP_PCS    = 4'b1110;
    localparam logic [OP_W-1:0] OP_HLT    = 4'b1111;

    localparam logic [COND_W-1:0] COND_NE  = 3'b000;
    localparam logic [COND_W-1:0] COND_EQ  = 3'b001;
    localparam logic [COND_W-1:0] COND_GT  = 3'b010;
    localparam logic [COND_W-1:0] COND_LT  = 3'b011;
    localparam logic [COND_W-1:0] COND_GTE = 3'b100;
    localparam logic [COND_W-1:0] COND_LTE = 3'b101;
    localparam logic [COND_W-1:0] COND_OVF = 3'b110;
    localparam logic [COND_W-1:0] COND_UNC = 3'b111;

    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 0;

    typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/flag_wr_dec.sv
// Opcode to {Z,V,N} flag write-mask decoder; an all-zero mask means the opcode writes no flags.
module flag_wr_dec
    import wisc_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    output flags_t          wr_mask_c
);

    always_comb begin
        wr_mask_c = '0;
        case (opcode)
            OP_ADD, OP_SUB: begin
                wr_mask_c[FLAG_Z] = 1'b1;
                wr_mask_c[FLAG_V] = 1'b1;
                wr_mask_c[FLAG_N] = 1'b1;
            end
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
                wr_mask_c[FLAG_Z] = 1'b1;
            end
            default: wr_mask_c = '0;
        endcase
    end

endmodule

// File: rtl/flag_unit.sv
// Architectural Z/V/N flag register with EX-stage commit and ID-stage branch hazard stall.
// Build option FLAG_FWD_EN: forward EX flags combinationally onto F and never stall.
module flag_unit
    import wisc_pkg::*;
#(
    parameter int unsigned CNT_W = 16
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ex_valid,
    input  logic                ex_hold,
    input  logic [OP_W-1:0]     ex_opcode,
    input  logic                alu_z,
    input  logic                alu_v,
    input  logic                alu_n,
    input  logic                id_valid,
    input  logic [OP_W-1:0]     id_opcode,
    input  logic [COND_W-1:0]   id_cond,
    output flags_t              F,
    output logic                flag_stall,
    output logic [CNT_W-1:0]    stall_cnt
);

    flags_t wr_mask_c;
    flags_t alu_flags_c;
    flags_t merged_c;
    flags_t flag_q;
    logic   writer_c;
    logic   commit_c;
    logic   cond_br_c;
    logic   hazard_c;

    flag_wr_dec u_ex_dec (
        .opcode    (ex_opcode),
        .wr_mask_c (wr_mask_c)
    );

    assign alu_flags_c = {alu_z, alu_v, alu_n};
    assign writer_c    = |wr_mask_c;
    assign commit_c    = ex_valid && !ex_hold && writer_c;
    assign merged_c    = (flag_q & ~wr_mask_c) | (alu_flags_c & wr_mask_c);

    // Hazard ignores ex_hold: a held writer still owes the branch its flags.
    assign cond_br_c = id_valid && ((id_opcode == OP_B) || (id_opcode == OP_BR))
                       && (id_cond != COND_UNC);
    assign hazard_c  = cond_br_c && ex_valid && writer_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= '0;
        end else if (commit_c) begin
            flag_q <= merged_c;
        end
    end

`ifdef FLAG_FWD_EN
    logic unused_hazard;
    assign unused_hazard = hazard_c;
    assign F             = (ex_valid && writer_c) ? merged_c : flag_q;
    assign flag_stall    = 1'b0;
`else
    assign F          = flag_q;
    assign flag_stall = hazard_c;
`endif

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (flag_stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_flag_unit.sv
// Scoreboard bench for flag_unit: a wide-counter instance and a 2-bit-counter instance share stimulus.
module tb_flag_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_hold;
    logic [3:0]  ex_opcode;
    logic        alu_z, alu_v, alu_n;
    logic        id_valid;
    logic [3:0]  id_opcode;
    logic [2:0]  id_cond;
    logic [2:0]  f_main, f_sat;
    logic        stall_main, stall_sat;
    logic [15:0] cnt_main;
    logic [1:0]  cnt_sat;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  f;
        logic [15:0] cnt;
        logic [1:0]  sat;
        string       tag;
    } exp_t;

    exp_t sb[$];

    logic [2:0]  m_flags;
    logic [15:0] m_cnt;
    logic [1:0]  m_sat;

    always #5 clk = ~clk;

    flag_unit #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_hold(ex_hold),
        .ex_opcode(ex_opcode), .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_cond(id_cond),
        .F(f_main), .flag_stall(stall_main), .stall_cnt(cnt_main)
    );

    flag_unit #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_hold(ex_hold),
        .ex_opcode(ex_opcode), .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_cond(id_cond),
        .F(f_sat), .flag_stall(stall_sat), .stall_cnt(cnt_sat)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] ref_mask(input logic [3:0] op);
        if (op == 4'd0 || op == 4'd1) return 3'b111;
        if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6) return 3'b100;
        return 3'b000;
    endfunction

    // One cycle: drive at negedge, check combinational outputs, queue post-edge expectations.
    task automatic step(input logic v, input logic h, input logic [3:0] op, input logic [2:0] zvn,
                        input logic iv, input logic [3:0] iop, input logic [2:0] cond,
                        input bit rst_pulse, input string tag);
        logic [2:0] mask;
        logic       writer, hz, exp_st;
        logic [2:0] exp_f;
        exp_t       e, got;
        @(negedge clk);
        ex_valid = v; ex_hold = h; ex_opcode = op;
        {alu_z, alu_v, alu_n} = zvn;
        id_valid = iv; id_opcode = iop; id_cond = cond;
        mask   = ref_mask(op);
        writer = (mask != 3'b000);
        hz     = iv && (iop == 4'b1100 || iop == 4'b1101) && (cond != 3'b111) && v && writer;
        #1;
`ifdef FLAG_FWD_EN
        exp_st = 1'b0;
        exp_f  = (v && writer) ? ((m_flags & ~mask) | (zvn & mask)) : m_flags;
`else
        exp_st = hz;
        exp_f  = m_flags;
`endif
        check_val({tag, "_stall"}, 32'(stall_main), 32'(exp_st));
        check_val({tag, "_stall_sat"}, 32'(stall_sat), 32'(exp_st));
        check_val({tag, "_f_now"}, 32'(f_main), 32'(exp_f));
        if (rst_pulse) begin
            #1 rst_n = 1'b0;
            #1;
            check_val({tag, "_rst_f"}, 32'(f_main), 32'(0));
            check_val({tag, "_rst_cnt"}, 32'(cnt_main), 32'(0));
            check_val({tag, "_rst_sat"}, 32'(cnt_sat), 32'(0));
            m_flags = 3'b000; m_cnt = 16'd0; m_sat = 2'd0;
            rst_n = 1'b1;
        end
        if (v && !h && writer) m_flags = (m_flags & ~mask) | (zvn & mask);
        if (exp_st) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (m_sat != 2'b11) m_sat = m_sat + 2'd1;
        end
`ifdef FLAG_FWD_EN
        e.f = (v && writer) ? ((m_flags & ~mask) | (zvn & mask)) : m_flags;
`else
        e.f = m_flags;
`endif
        e.cnt = m_cnt; e.sat = m_sat; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check_val({got.tag, "_f"}, 32'(f_main), 32'(got.f));
        check_val({got.tag, "_cnt"}, 32'(cnt_main), 32'(got.cnt));
        check_val({got.tag, "_sat"}, 32'(cnt_sat), 32'(got.sat));
    endtask

    task automatic idle(input string tag);
        step(1'b0, 1'b0, 4'd0, 3'b000, 1'b0, 4'd0, 3'b000, 1'b0, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_hold = 1'b0; ex_opcode = 4'd0;
        alu_z = 1'b0; alu_v = 1'b0; alu_n = 1'b0;
        id_valid = 1'b0; id_opcode = 4'd0; id_cond = 3'd0;
        m_flags = 3'b000; m_cnt = 16'd0; m_sat = 2'd0;
        #3;
        check_val("reset_f", 32'(f_main), 32'(0));
        check_val("reset_stall", 32'(stall_main), 32'(0));
        check_val("reset_cnt", 32'(cnt_main), 32'(0));
        check_val("reset_sat", 32'(cnt_sat), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) idle("idle");

        // ADD writes all flags, XOR writes Z only.
        step(1'b1, 1'b0, 4'b0000, 3'b011, 1'b0, 4'd0, 3'd0, 1'b0, "add");
        step(1'b1, 1'b0, 4'b0010, 3'b100, 1'b0, 4'd0, 3'd0, 1'b0, "xor");
        // Writer vs conditional branch, then vs unconditional branch.
        step(1'b1, 1'b0, 4'b0001, 3'b000, 1'b1, 4'b1100, 3'b001, 1'b0, "sub_beq");
        idle("post_sub");
        step(1'b1, 1'b0, 4'b0001, 3'b100, 1'b1, 4'b1100, 3'b111, 1'b0, "sub_bunc");
        // Held ADD for two cycles against BR GT, then release.
        step(1'b1, 1'b1, 4'b0000, 3'b011, 1'b1, 4'b1101, 3'b010, 1'b0, "hold1");
        step(1'b1, 1'b1, 4'b0000, 3'b011, 1'b1, 4'b1101, 3'b010, 1'b0, "hold2");
        step(1'b1, 1'b0, 4'b0000, 3'b011, 1'b1, 4'b1101, 3'b010, 1'b0, "hold_rel");
        // Non-hazard mixes.
        step(1'b1, 1'b0, 4'b0101, 3'b100, 1'b1, 4'b1000, 3'b001, 1'b0, "sra_lw");
        step(1'b1, 1'b0, 4'b0011, 3'b011, 1'b1, 4'b1100, 3'b001, 1'b0, "red_beq");
        step(1'b1, 1'b0, 4'b0000, 3'b010, 1'b0, 4'b1100, 3'b001, 1'b0, "add_idinv");
        step(1'b0, 1'b0, 4'b0001, 3'b111, 1'b1, 4'b1100, 3'b000, 1'b0, "exinv_bne");
        step(1'b1, 1'b1, 4'b0110, 3'b000, 1'b1, 4'b1110, 3'b000, 1'b0, "ror_hold_pcs");
        // Reset pulsed mid-stall with the hazard still present.
        step(1'b1, 1'b0, 4'b0001, 3'b101, 1'b1, 4'b1100, 3'b110, 1'b1, "rst_mid");
        // Back-to-back writers: 2-bit counter saturates.
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, (i % 2 == 0) ? 4'b0000 : 4'b0100, 3'(i + 1),
                 1'b1, 4'b1100, 3'b001, 1'b0, "b2b");
        idle("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
